pulse_arbiter: RTL and testbench
================================

PULSE_ARBITER -- requirements
Module: pulse_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesters (2..8).
REQ-002 Parameter ACT_LEN, 3, ACTIVE phase length in cycles (1..15).
REQ-003 Parameter GUARD_LEN, 2, GUARD phase length in cycles (0..15).
REQ-004 Port clk  input  1  clock; all state changes on rising edge.
REQ-005 Port rstn  input  1  reset, asynchronous, active-low.
REQ-006 Port en  input  1  arbitration enable; sampled only in IDLE.
REQ-007 Port req  input  NREQ  level request per requester; held until that requester's ack.
REQ-008 Port gnt  output  NREQ  one-hot grant; high for the owner during the whole ACTIVE phase.
REQ-009 Port ack  output  NREQ  one-cycle completion pulse to the owner.
REQ-010 Port y_out  output  1  shared pulse output; high exactly during ACTIVE.
REQ-011 Port busy  output  1  high in ACTIVE or GUARD.
REQ-012 Port state  output  2  encoded state: IDLE=00, ACTIVE=01, GUARD=10; 11 is unused.
REQ-013 Port owner  output  clog2(NREQ)  index of the current or most recent owner.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACTIVE and GUARD; state 11 SHALL return to IDLE on the next edge with all outputs low.
REQ-015 In IDLE with en=1 and req!=0, the next edge SHALL enter ACTIVE, set owner to the winner, and load the 4-bit phase counter with ACT_LEN-1.
REQ-016 The winner SHALL be the first asserted req scanning from (owner+1) mod NREQ upward with wrap (round-robin).
REQ-017 In IDLE with en=0 or req=0, the block SHALL remain in IDLE, and gnt, y_out and busy SHALL be 0.
REQ-018 ACTIVE SHALL last exactly ACT_LEN cycles, with y_out=1 and gnt[owner]=1 throughout and the counter decrementing each cycle.
REQ-019 ack[owner] SHALL be 1 only in the last ACTIVE cycle (counter==0) and 0 at all other times.
REQ-020 From the last ACTIVE cycle, the next edge SHALL enter GUARD with the counter set to GUARD_LEN-1 when GUARD_LEN>0, or enter IDLE when GUARD_LEN=0.
REQ-021 GUARD SHALL last exactly GUARD_LEN cycles with y_out=0, gnt=0 and busy=1, then SHALL enter IDLE.
REQ-022 The minimum start-to-start period SHALL be ACT_LEN+GUARD_LEN+1 cycles; one IDLE cycle is mandatory between bursts.
REQ-023 Deasserting the owner's req during ACTIVE SHALL NOT abort the burst; it SHALL run to completion and ack SHALL still pulse.
REQ-024 Changes to req or en during ACTIVE or GUARD SHALL have no effect until the next IDLE cycle.
REQ-025 gnt, ack, y_out, busy and state SHALL be driven directly from registered state and counter (no req-to-output combinational path).

Reset
REQ-026 rstn=0 SHALL immediately force: state=IDLE, counter=0, gnt=0, ack=0, y_out=0, busy=0, owner=NREQ-1.
REQ-027 Reset asserted mid-ACTIVE or mid-GUARD SHALL abort the burst without an ack.
REQ-028 After reset, req[0] SHALL hold first priority.

Verification
REQ-029 Reset release, en=1, req=0001 before edge 0 -> ACTIVE in cycles 1-3 with gnt=0001 and y_out=1; ack=0001 in cycle 3; GUARD in cycles 4-5; IDLE in cycle 6.
REQ-030 req=1111 held, each requester dropping its req after its ack -> grants in order 0,1,2,3, with starts 6 cycles apart.
REQ-031 req[2] only; req[2] dropped in the 2nd ACTIVE cycle -> y_out still 3 cycles, ack[2] pulses, owner=2.
REQ-032 en=0 with req=0011 -> IDLE held, all outputs 0; en=0 asserted during ACTIVE -> burst completes, then IDLE held.
REQ-033 rstn low in the 2nd ACTIVE cycle with owner=1 -> all outputs 0 immediately and no ack; after release with req=0011, req[0] wins.
REQ-034 GUARD_LEN=0 with req=0001 held -> y_out high 3 cycles, low 1 cycle, repeating with period 4.

Source files
------------

// File: rtl/pulse_arbiter_if.sv
// Request/grant bundle between the pulse arbiter and its requesters.
// The arbiter owns the slave side; requesters drive en/req through master.
interface pulse_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int OW = $clog2(NREQ);

  logic            en;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic            y_out;
  logic            busy;
  logic [1:0]      state;
  logic [OW-1:0]   owner;

  modport master (
    output en, req,
    input  gnt, ack, y_out, busy, state, owner
  );

  modport slave (
    input  en, req,
    output gnt, ack, y_out, busy, state, owner
  );
endinterface

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter granting one requester an ACT_LEN-cycle pulse burst followed by a GUARD_LEN cooldown.
// Start-to-start period ACT_LEN+GUARD_LEN+1; req/en only sampled in IDLE, outputs decode registered state only.
module pulse_arbiter #(
  parameter int NREQ      = 4,
  parameter int ACT_LEN   = 3,
  parameter int GUARD_LEN = 2
) (
  input logic            clk,
  input logic            rstn,
  pulse_arbiter_if.slave bus
);
  localparam int         OW         = $clog2(NREQ);
  localparam logic [3:0] ACT_LOAD   = 4'(ACT_LEN - 1);
  localparam logic [3:0] GUARD_LOAD = 4'((GUARD_LEN > 0) ? GUARD_LEN - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    GUARD  = 2'b10
  } state_t;

  state_t            st_q, st_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [OW:0]       rot_sh;
  logic              win_vld;
  logic [OW-1:0]     win_idx;
  logic [NREQ-1:0]   owner_oh;
  logic              act;

  // Rotate req so bit 0 is the requester right after the last owner.
  assign req_dbl = {bus.req, bus.req};
  assign rot_sh  = {1'b0, owner_q} + (OW+1)'(1);
  assign req_rot = NREQ'(req_dbl >> rot_sh);

  always_comb begin
    win_vld = |bus.req;
    win_idx = owner_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) win_idx = OW'((int'(owner_q) + 1 + k) % NREQ);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      owner_q <= OW'(NREQ - 1);
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    case (st_q)
      IDLE: begin
        if (bus.en && win_vld) begin
          st_d    = ACTIVE;
          cnt_d   = ACT_LOAD;
          owner_d = win_idx;
        end
      end
      ACTIVE: begin
        if (cnt_q == 4'd0) begin
          if (GUARD_LEN > 0) begin
            st_d  = GUARD;
            cnt_d = GUARD_LOAD;
          end else begin
            st_d  = IDLE;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GUARD: begin
        if (cnt_q == 4'd0) begin
          st_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  assign owner_oh  = NREQ'(1) << owner_q;
  assign act       = (st_q == ACTIVE);
  assign bus.state = st_q;
  assign bus.y_out = act;
  assign bus.busy  = act || (st_q == GUARD);
  assign bus.gnt   = act ? owner_oh : '0;
  assign bus.ack   = (act && cnt_q == 4'd0) ? owner_oh : '0;
  assign bus.owner = owner_q;
endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed bench for pulse_arbiter: main instance (ACT 3, GUARD 2) plus a GUARD_LEN=0 instance.
module tb_pulse_arbiter;
  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pulse_arbiter_if #(.NREQ(4)) b0 ();
  pulse_arbiter_if #(.NREQ(4)) b1 ();

  pulse_arbiter #(.NREQ(4), .ACT_LEN(3), .GUARD_LEN(2)) u0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b0)
  );

  pulse_arbiter #(.NREQ(4), .ACT_LEN(3), .GUARD_LEN(0)) u1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [1:0] st, input logic [3:0] g,
                      input logic [3:0] a, input logic y, input logic bz);
    check({tag, ".state"}, 32'(b0.state), 32'(st));
    check({tag, ".gnt"},   32'(b0.gnt),   32'(g));
    check({tag, ".ack"},   32'(b0.ack),   32'(a));
    check({tag, ".y_out"}, 32'(b0.y_out), 32'(y));
    check({tag, ".busy"},  32'(b0.busy),  32'(bz));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] ypat;
    logic [11:0] apat;
    ypat = 12'h777;
    apat = 12'h444;
    rstn    = 1'b0;
    b0.en   = 1'b0;
    b0.req  = 4'b0000;
    b1.en   = 1'b0;
    b1.req  = 4'b0000;
    repeat (2) step();
    chk0("rst", 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    check("rst.owner", 32'(b0.owner), 32'd3);

    // Single burst right out of reset
    b0.en  = 1'b1;
    b0.req = 4'b0001;
    rstn   = 1'b1;
    step(); chk0("t29.c1", 2'b01, 4'h1, 4'h0, 1'b1, 1'b1);
    check("t29.owner", 32'(b0.owner), 32'd0);
    step(); chk0("t29.c2", 2'b01, 4'h1, 4'h0, 1'b1, 1'b1);
    step(); chk0("t29.c3", 2'b01, 4'h1, 4'h1, 1'b1, 1'b1);
    b0.req = 4'b0000;
    step(); chk0("t29.c4", 2'b10, 4'h0, 4'h0, 1'b0, 1'b1);
    step(); chk0("t29.c5", 2'b10, 4'h0, 4'h0, 1'b0, 1'b1);
    step(); chk0("t29.c6", 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);

    // Round-robin sweep with all requesters pending
    rstn = 1'b0;
    step();
    rstn   = 1'b1;
    b0.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk0($sformatf("t30.start%0d", k), 2'b01, 4'(1 << k), 4'h0, 1'b1, 1'b1);
      check($sformatf("t30.owner%0d", k), 32'(b0.owner), 32'(k));
      step();
      step();
      chk0($sformatf("t30.ack%0d", k), 2'b01, 4'(1 << k), 4'(1 << k), 1'b1, 1'b1);
      b0.req[k] = 1'b0;
      step();
      step();
      step();
      chk0($sformatf("t30.idle%0d", k), 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    end

    // Owner drops req mid-burst
    b0.req = 4'b0100;
    step(); chk0("t31.a1", 2'b01, 4'h4, 4'h0, 1'b1, 1'b1);
    check("t31.owner", 32'(b0.owner), 32'd2);
    step(); chk0("t31.a2", 2'b01, 4'h4, 4'h0, 1'b1, 1'b1);
    b0.req = 4'b0000;
    step(); chk0("t31.a3", 2'b01, 4'h4, 4'h4, 1'b1, 1'b1);
    step(); chk0("t31.g1", 2'b10, 4'h0, 4'h0, 1'b0, 1'b1);
    step();
    step(); chk0("t31.idle", 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    check("t31.owner_kept", 32'(b0.owner), 32'd2);

    // Enable low holds IDLE; dropping enable mid-burst does not abort it
    b0.en  = 1'b0;
    b0.req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      step(); chk0($sformatf("t32.hold%0d", k), 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    end
    b0.en = 1'b1;
    step(); chk0("t32.a1", 2'b01, 4'h1, 4'h0, 1'b1, 1'b1);
    check("t32.owner", 32'(b0.owner), 32'd0);
    b0.en = 1'b0;
    step();
    step(); chk0("t32.a3", 2'b01, 4'h1, 4'h1, 1'b1, 1'b1);
    b0.req = 4'b0010;
    step();
    step();
    step(); chk0("t32.idle", 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    step(); chk0("t32.held", 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);

    // Reset in the middle of an ACTIVE burst
    b0.en = 1'b1;
    step(); chk0("t33.a1", 2'b01, 4'h2, 4'h0, 1'b1, 1'b1);
    check("t33.owner", 32'(b0.owner), 32'd1);
    step(); chk0("t33.a2", 2'b01, 4'h2, 4'h0, 1'b1, 1'b1);
    rstn = 1'b0;
    #1;
    chk0("t33.rst", 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    check("t33.rst_owner", 32'(b0.owner), 32'd3);
    step(); chk0("t33.rst_hold", 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    b0.req = 4'b0011;
    rstn   = 1'b1;
    step(); chk0("t33.restart", 2'b01, 4'h1, 4'h0, 1'b1, 1'b1);
    check("t33.owner0", 32'(b0.owner), 32'd0);
    b0.req = 4'b0000;
    b0.en  = 1'b0;
    repeat (5) step();
    chk0("t33.idle", 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);

    // Zero-length guard: period ACT_LEN+1
    b1.en  = 1'b1;
    b1.req = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("t34.y%0d", k), 32'(b1.y_out), 32'(ypat[k]));
      check($sformatf("t34.ack%0d", k), 32'(b1.ack), apat[k] ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
